// File: rtl/delay_cfg_pkg.sv
// Shared configuration for the delay-line load scheduler: channel map,
// default widths and scheduler state encoding.
package delay_cfg_pkg;

  localparam int DEF_NUM_CH = 9;
  localparam int DEF_VAL_W  = 4;

  localparam int CH_R_WHOLE   = 0;
  localparam int CH_G_WHOLE   = 1;
  localparam int CH_B_WHOLE   = 2;
  localparam int CH_R_RISING  = 3;
  localparam int CH_G_RISING  = 4;
  localparam int CH_B_RISING  = 5;
  localparam int CH_R_FALLING = 6;
  localparam int CH_G_FALLING = 7;
  localparam int CH_B_FALLING = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first pending channel after last_grant,
// wrapping modulo NUM_CH. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_CH = 9
) (
  input  logic [NUM_CH-1:0]         pending,
  input  logic [$clog2(NUM_CH)-1:0] last_grant,
  output logic                      grant_valid,
  output logic [$clog2(NUM_CH)-1:0] grant_idx
);

  localparam int SEL_W = $clog2(NUM_CH);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      int unsigned c;
      c = (32'(last_grant) + k) % NUM_CH;
      if (!grant_valid && pending[SEL_W'(c)]) begin
        grant_valid = 1'b1;
        grant_idx   = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/delay_load_sched.sv
// Pushes per-channel delay settings through one shared load port, reloading
// only channels whose request differs from the last loaded value.
module delay_load_sched
  import delay_cfg_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int VAL_W         = DEF_VAL_W,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                      clk_x10,
  input  logic                      g_rst,
  input  logic [NUM_CH*VAL_W-1:0]   delay_value,
  input  logic                      force_all,
  output logic                      ld_valid,
  input  logic                      ld_ready,
  output logic [$clog2(NUM_CH)-1:0] ld_sel,
  output logic [VAL_W-1:0]          ld_data,
  output logic                      busy,
  output logic                      all_synced,
  output logic                      sync_pulse
);

  localparam int SEL_W = $clog2(NUM_CH);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

  sched_state_t state, state_next;

  logic [VAL_W-1:0]  req    [NUM_CH];
  logic [VAL_W-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] init_pend;
  logic [NUM_CH-1:0] pending;
  logic [SEL_W-1:0]  last_grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_valid;
  logic [CNT_W-1:0]  settle_cnt;
  logic              grant_fire;
  logic              handshake;
  logic              synced_next;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      req[i]     = delay_value[i*VAL_W +: VAL_W];
      pending[i] = init_pend[i] | (req[i] != shadow[i]);
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign grant_fire  = (state == ST_IDLE) && grant_valid;
  assign handshake   = (state == ST_LOAD) && ld_valid && ld_ready;
  assign synced_next = (state == ST_IDLE) && (pending == '0);
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk_x10) begin
    if (g_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (grant_valid) state_next = ST_LOAD;
      ST_LOAD:   if (handshake) state_next = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_SETTLE;
      ST_SETTLE: if (settle_cnt == '0) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_x10) begin
    if (g_rst) begin
      ld_valid   <= 1'b0;
      ld_sel     <= '0;
      ld_data    <= '0;
      last_grant <= SEL_W'(NUM_CH - 1);
      settle_cnt <= '0;
      all_synced <= 1'b0;
      sync_pulse <= 1'b0;
    end else begin
      if (grant_fire) begin
        ld_valid   <= 1'b1;
        ld_sel     <= grant_idx;
        ld_data    <= req[grant_idx];
        last_grant <= grant_idx;
      end
      if (handshake) begin
        ld_valid   <= 1'b0;
        settle_cnt <= SETTLE_LOAD;
      end else if (state == ST_SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      all_synced <= synced_next;
      sync_pulse <= synced_next & ~all_synced;
    end
  end

  // force_all is applied last so a set on the handshake edge wins over the clear
  always_ff @(posedge clk_x10) begin
    if (g_rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      init_pend <= '1;
    end else begin
      if (handshake) begin
        shadow[ld_sel]    <= ld_data;
        init_pend[ld_sel] <= 1'b0;
      end
      if (force_all) init_pend <= '1;
    end
  end

endmodule

// File: doc/delay_load_sched.md
# delay_load_sched

Round-robin scheduler that pushes the nine R/G/B delay settings (whole/rising/falling per colour) from the button-driven control logic into a single shared delay-line load port, one channel at a time. It keeps a shadow of the last value loaded per channel, reloads only channels whose requested value differs from the shadow, and inserts a settle gap after each load. It sits between the control block's `*_delay_value` outputs and the PAM4/RGB delay-line configuration interface, in the `clk_x10` domain.

## Interface
- `NUM_CH`, 9, number of delay channels; fixed channel order: r/g/b_whole = 0..2, r/g/b_rising = 3..5, r/g/b_falling = 6..8
- `VAL_W`, 4, delay value width
- `SETTLE_CYCLES`, 8, idle cycles after each accepted load; 0 disables the settle gap
- `clk_x10`  in  1  single clock, all logic on rising edge
- `g_rst`  in  1  reset, synchronous, active-high
- `delay_value`  in  NUM_CH*VAL_W  requested values, channel i at bits [i*VAL_W +: VAL_W]
- `force_all`  in  1  one-cycle pulse; marks all channels for reload
- `ld_valid`  out  1  load request to the delay-line port
- `ld_ready`  in  1  delay-line port accepts the load
- `ld_sel`  out  4  channel index of the current load ($clog2(NUM_CH))
- `ld_data`  out  VAL_W  value being loaded
- `busy`  out  1  FSM not in IDLE
- `all_synced`  out  1  no channel pending and FSM in IDLE
- `sync_pulse`  out  1  one-cycle pulse on the rising edge of `all_synced`

## Operation
- Per channel: `shadow[i]` (VAL_W) and `init_pend[i]` (1 bit). `pending[i] = init_pend[i] | (delay_value[i] != shadow[i])`, combinational.
- Reset: all shadows 0; all `init_pend` set, so every channel is loaded once after reset.
- `force_all` sets all `init_pend`. It does not abort a load in progress.
- FSM states: IDLE, LOAD, SETTLE.
  - IDLE: if any `pending`, the arbiter grants one channel. `ld_sel` and `ld_data` register the granted index and value, `ld_valid` is set, and the FSM goes to LOAD. If nothing is pending, it stays in IDLE.
  - LOAD: `ld_valid`, `ld_sel` and `ld_data` are held stable until `ld_valid && ld_ready` at a clock edge. On that edge: `shadow[sel] <= ld_data`, `init_pend[sel] <= 0`, `ld_valid <= 0`. Next state is SETTLE, or IDLE if `SETTLE_CYCLES == 0`.
  - SETTLE: down-counter loaded with `SETTLE_CYCLES - 1`; go to IDLE when it reaches 0.
- A change on `delay_value` during LOAD does not alter `ld_data`. After the handshake the shadow differs from the new input, so the channel stays pending and is reloaded in a later grant.
- `force_all` on the handshake edge of channel i: set wins, and `init_pend[i]` stays 1.
- Arbitration is round-robin. Search starts at `last_grant + 1` modulo NUM_CH and picks the first pending channel. After reset `last_grant = NUM_CH-1`, so channel 0 is searched first. Index 8 wraps to 0.
- `ld_sel` is never ≥ NUM_CH.

## Timing
- Reset values: `ld_valid` 0, `ld_sel` 0, `ld_data` 0, `busy` 0, `all_synced` 0, `sync_pulse` 0. FSM in IDLE, settle counter 0.
- `g_rst` asserted mid-LOAD drops `ld_valid` at that edge with no handshake. The downstream port must ignore the partial request.
- Latency: `pending` true in IDLE at edge N gives `ld_valid` high from edge N+1.
- Per-channel cost: 1 IDLE cycle + ≥1 LOAD cycle + SETTLE_CYCLES.
  - With `ld_ready` tied high and defaults, that is 10 cycles per channel.
  - Post-reset full sync takes 90 cycles.
- `all_synced` is registered and lags state and pending by one cycle.
- `sync_pulse` is high exactly one cycle: the cycle `all_synced` goes 0→1.

## Structure
- Shared package `delay_cfg_pkg` holds:
  - channel index constants CH_R_WHOLE..CH_B_FALLING (0..8)
  - NUM_CH, VAL_W defaults
  - FSM state encoding (IDLE=0, LOAD=1, SETTLE=2)
- One sub-module, `rr_arbiter`: parameterised NUM_CH. Inputs are the `pending` vector and `last_grant`; outputs are `grant_valid` and `grant_idx`. Purely combinational; the pointer register lives in the parent.

## Test plan
- Reset, then `ld_ready`=1 with all values 0 → loads on channels 0,1,…,8 in order, each with `ld_data`=0. `sync_pulse` fires once after the channel-8 load plus 8 settle cycles; nothing further follows.
- After sync, set channel 4 to 4'hA → exactly one load with `ld_sel`=4, `ld_data`=A, `ld_valid` rising 1 cycle after the change. Then `all_synced` returns to 1.
- Channels 2 and 7 change together while last grant was 5 → order is 7 then 2 (wrap). Repeat with last grant 8 → order is 2 then 7.
- `ld_ready` held low 20 cycles during a load of channel 3=5, input changed to 6 mid-wait → `ld_data` stays 5 until the handshake, then a second load of channel 3 with value 6.
- `force_all` pulse while synced → all nine channels reloaded with their current values, in round-robin order from `last_grant+1`.
- `g_rst` during LOAD of channel 6 → `ld_valid` 0 at that edge and all outputs at reset values. A full 0..8 reload sequence restarts after release.
